// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle RV32I control FSM and its datapath.
// The master side is the FSM. The slave side is the datapath that decodes the IR and consumes the enables.
interface multicycle_control_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic       reg_write;
    logic       illegal_instr;
    logic [3:0] state;

    modport master (
        input  op, funct3, funct7b5, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
               alu_src_b, alu_control, reg_write, illegal_instr, state
    );

    modport slave (
        output op, funct3, funct7b5, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
               alu_src_b, alu_control, reg_write, illegal_instr, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM: sequences lw/sw/R/I/beq/jal and drives ALU selects and write enables.
// Moore outputs per state, with Mealy terms on mem_ready (FETCH), zero (BEQ) and illegal decode (DECODE).
module multicycle_control #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input logic                  clk,
    input logic                  reset,
    multicycle_control_if.master ctrl_bus
);
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    logic       w_illegal;
    logic [2:0] w_alu_decoded;
    logic       w_pc_write;
    logic       w_adr_src;
    logic       w_mem_write;
    logic       w_ir_write;
    logic [1:0] w_result_src;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [2:0] w_alu_control;
    logic       w_reg_write;
    logic       w_illegal_instr;

    function automatic logic f_alu_funct3_ok(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    function automatic logic f_is_illegal(input logic [6:0] op, input logic [2:0] f3);
        logic v;
        case (op)
            OP_LOAD, OP_STORE, OP_JAL: v = 1'b0;
            OP_RTYPE, OP_ITYPE:        v = !f_alu_funct3_ok(f3);
            OP_BEQ:                    v = (f3 != 3'b000);
            default:                   v = 1'b1;
        endcase
        return v;
    endfunction

    // op[5] separates R-type from I-type, so addi never becomes a subtract.
    function automatic logic [2:0] f_alu_decode(input logic [6:0] op, input logic [2:0] f3,
                                                input logic f7b5);
        logic [2:0] v;
        case (f3)
            3'b000:  v = (op[5] && f7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  v = ALU_SLT;
            3'b110:  v = ALU_OR;
            3'b111:  v = ALU_AND;
            default: v = ALU_ADD;
        endcase
        return v;
    endfunction

    assign w_illegal     = f_is_illegal(ctrl_bus.op, ctrl_bus.funct3);
    assign w_alu_decoded = f_alu_decode(ctrl_bus.op, ctrl_bus.funct3, ctrl_bus.funct7b5);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RESET_STATE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:    w_next_state = ctrl_bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (!w_illegal) begin
                    case (ctrl_bus.op)
                        OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
                        OP_RTYPE:          w_next_state = S_EXECUTER;
                        OP_ITYPE:          w_next_state = S_EXECUTEI;
                        OP_BEQ:            w_next_state = S_BEQ;
                        OP_JAL:            w_next_state = S_JAL;
                        default:           w_next_state = S_FETCH;
                    endcase
                end
            end
            S_MEMADR:   w_next_state = ctrl_bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next_state = ctrl_bus.mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_next_state = S_FETCH;
            S_MEMWRITE: w_next_state = ctrl_bus.mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: w_next_state = S_ALUWB;
            S_EXECUTEI: w_next_state = S_ALUWB;
            S_ALUWB:    w_next_state = S_FETCH;
            S_BEQ:      w_next_state = S_FETCH;
            S_JAL:      w_next_state = S_ALUWB;
            default:    w_next_state = S_FETCH;
        endcase
    end

    always_comb begin
        w_pc_write      = 1'b0;
        w_adr_src       = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_result_src    = 2'b00;
        w_alu_src_a     = 2'b00;
        w_alu_src_b     = 2'b00;
        w_alu_control   = ALU_ADD;
        w_reg_write     = 1'b0;
        w_illegal_instr = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                w_ir_write   = ctrl_bus.mem_ready;
                w_pc_write   = ctrl_bus.mem_ready;
            end
            S_DECODE: begin
                w_alu_src_a     = 2'b01;
                w_alu_src_b     = 2'b01;
                w_illegal_instr = w_illegal;
            end
            S_MEMADR: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
            end
            S_MEMREAD:  w_adr_src = 1'b1;
            S_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXECUTER: begin
                w_alu_src_a   = 2'b10;
                w_alu_control = w_alu_decoded;
            end
            S_EXECUTEI: begin
                w_alu_src_a   = 2'b10;
                w_alu_src_b   = 2'b01;
                w_alu_control = w_alu_decoded;
            end
            S_ALUWB:    w_reg_write = 1'b1;
            S_BEQ: begin
                w_alu_src_a   = 2'b10;
                w_alu_control = ALU_SUB;
                w_pc_write    = ctrl_bus.zero;
            end
            S_JAL: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b10;
                w_pc_write  = 1'b1;
            end
            default: ;
        endcase
        // Reset kills every enable combinationally so no write can slip through before the clock.
        if (reset) begin
            w_pc_write      = 1'b0;
            w_mem_write     = 1'b0;
            w_ir_write      = 1'b0;
            w_reg_write     = 1'b0;
            w_illegal_instr = 1'b0;
            w_adr_src       = 1'b0;
            w_alu_src_a     = 2'b00;
            w_alu_src_b     = 2'b10;
            w_alu_control   = ALU_ADD;
            w_result_src    = 2'b10;
        end
    end

    assign ctrl_bus.pc_write      = w_pc_write;
    assign ctrl_bus.adr_src       = w_adr_src;
    assign ctrl_bus.mem_write     = w_mem_write;
    assign ctrl_bus.ir_write      = w_ir_write;
    assign ctrl_bus.result_src    = w_result_src;
    assign ctrl_bus.alu_src_a     = w_alu_src_a;
    assign ctrl_bus.alu_src_b     = w_alu_src_b;
    assign ctrl_bus.alu_control   = w_alu_control;
    assign ctrl_bus.reg_write     = w_reg_write;
    assign ctrl_bus.illegal_instr = w_illegal_instr;
    assign ctrl_bus.state         = r_state;
endmodule
